nt_level_tracker: RTL and testbench
===================================

Name: nt_level_tracker

Overview:
- Drives the inc/dec/fast/setval command interface of a neurotransmitter level resource, so it is the command-generating end of that interface.
- Steers the resource value toward a requested target level, using the resource's current value as feedback.
- Rate-limits commands and uses fast steps for large errors.
- Detects a resource that does not follow its commands (stall).
- Lets higher-level mood logic request an absolute neurotransmitter level instead of issuing raw inc/dec commands.

Parameters:
- N, 7: width of the target and value buses.
- PERIOD, 4: cycles between command opportunities (ticks); must be at least 2.
- DEADBAND, 2: an absolute error at or below this counts as on target.
- FAST_THRESH, 16: an absolute error at or above this asserts fast; must exceed the resource FAST_STEP.
- SET_VAL, 64: the resource's setval load value, used for the shortcut.
- STALL_LIMIT, 8: number of consecutive non-improving ticks that declares a stall.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  tracking enable.
- target  in  N  requested level.
- value  in  N  current resource value (feedback).
- inc  out  1  one-cycle increment command.
- dec  out  1  one-cycle decrement command.
- fast  out  1  qualifies inc/dec as a fast step.
- setval  out  1  one-cycle load-SET_VAL command.
- busy  out  1  high while in RAMP.
- settled  out  1  high while in SETTLE.
- stalled  out  1  high while in FAULT.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: state IDLE, all outputs 0, prescaler 0, stall counter 0, prev_err 0. Reset asserted mid-pulse forces all outputs to 0 at that edge.
- Arithmetic: diff = target - value, computed signed in N+1 bits. err = |diff|, N bits.
- Prescaler: counts 0..PERIOD-1 in RAMP/SETTLE and wraps. A tick is the edge where the count equals PERIOD-1. The prescaler is held at 0 in IDLE and FAULT.
- Outputs inc/dec/fast/setval are registered. They load a decision only on a RAMP tick edge and load 0 on every other edge. Each pulse is therefore exactly 1 cycle wide, with at most one pulse per PERIOD cycles.
- inc and dec are never both 1. setval is never asserted together with inc or dec. fast only accompanies inc or dec.
- Priority: rst_n, then enable=0, then tick logic. enable=0 in any state moves to IDLE at the next edge and zeroes all outputs at that edge, overriding a coincident tick.
- IDLE:
  - If enable and err > DEADBAND, go to RAMP: prescaler 0, prev_err = err, stall counter 0.
  - If enable and err <= DEADBAND, go to SETTLE.
- RAMP, evaluated on each tick in this order:
  - (a) err <= DEADBAND: go to SETTLE, no pulse.
  - (b) Stall counter: increments if err >= prev_err, otherwise clears. If the incremented count reaches STALL_LIMIT, go to FAULT with no pulse.
  - (c) Shortcut: if |target - SET_VAL| <= DEADBAND and err >= FAST_THRESH, pulse setval and go to SETTLE.
  - (d) Otherwise pulse inc (diff > 0) or dec (diff < 0), with fast = (err >= FAST_THRESH).
  - prev_err = err on every RAMP tick.
- SETTLE: on a tick, if err > DEADBAND, go to RAMP with stall counter 0 and prev_err = err. Target changes therefore take effect within PERIOD cycles.
- FAULT: no pulses; holds until enable=0, then goes to IDLE.
- Feedback latency: the resource updates value one cycle after a pulse. Because PERIOD >= 2, the next tick always samples the updated value.
- Saturation: target is always in range. A resource clamped by another driver shows up as a stall.

Test Plan:
All cases use default parameters and a bench model of the resource with FAST_STEP=3 and setval loading 64.
- Reset: hold rst_n=0 with enable=1 for 3 cycles -> all outputs 0, no pulse for the first PERIOD cycles after release.
- Small decrement: value=96, target=90, enable -> exactly 4 single dec pulses, 4 cycles apart, fast=0; value ends 92 and settled=1.
- Large increment: value=20, target=100 -> 22 fast inc pulses (value 86), then 12 single inc pulses; value ends 98, settled=1, no dec ever seen.
- Shortcut: value=120, target=64 -> first tick yields one setval pulse with no inc/dec; value 64; settled=1 at the next tick.
- Stall: model ignores commands, value=50, target=80 -> 7 inc pulses, then stalled=1 after the 8th tick with no further pulses; drop enable -> stalled=0 next cycle, state IDLE.
- Abort:
  - enable=0 on a tick edge mid-ramp -> no pulse at that edge, all outputs 0, busy=0.
  - Repeat with rst_n=0 instead of enable=0 -> same outputs.

Source files
------------

// File: rtl/nt_level_if.sv
// Command/feedback bundle between a level tracker and a neurotransmitter
// level resource.
//   enable  : tracking enable (tracker input)
//   target  : requested level (tracker input)
//   value   : current resource value, feedback (tracker input)
//   inc/dec : one-cycle step commands (tracker output)
//   fast    : qualifies inc/dec as a fast step (tracker output)
//   setval  : one-cycle load-SET_VAL command (tracker output)
//   busy/settled/stalled : tracker status (tracker output)
// master = command generator (tracker), slave = resource/controller side.
interface nt_level_if #(
    parameter int unsigned N = 7
);
    logic         enable;
    logic [N-1:0] target;
    logic [N-1:0] value;
    logic         inc;
    logic         dec;
    logic         fast;
    logic         setval;
    logic         busy;
    logic         settled;
    logic         stalled;

    modport master (
        input  enable,
        input  target,
        input  value,
        output inc,
        output dec,
        output fast,
        output setval,
        output busy,
        output settled,
        output stalled
    );

    modport slave (
        output enable,
        output target,
        output value,
        input  inc,
        input  dec,
        input  fast,
        input  setval,
        input  busy,
        input  settled,
        input  stalled
    );
endinterface

// File: rtl/nt_level_tracker.sv
// Closed-loop level tracker: steers a neurotransmitter level resource toward
// an absolute target by issuing rate-limited inc/dec/fast/setval commands,
// using the resource value as feedback, and flags a resource that stops
// following its commands.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : nt_level_if master modport (enable/target/value in,
//           inc/dec/fast/setval commands and busy/settled/stalled status out)
// All outputs are registered.
module nt_level_tracker #(
    parameter int unsigned N           = 7,
    parameter int unsigned PERIOD      = 4,
    parameter int unsigned DEADBAND    = 2,
    parameter int unsigned FAST_THRESH = 16,
    parameter int unsigned SET_VAL     = 64,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    nt_level_if.master bus
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

    localparam logic [N-1:0]  DB_LVL    = N'(DEADBAND);
    localparam logic [N-1:0]  FAST_LVL  = N'(FAST_THRESH);
    localparam logic [N-1:0]  SET_LVL   = N'(SET_VAL);
    localparam logic [PW-1:0] TICK_CNT  = PW'(PERIOD - 1);
    localparam logic [SW-1:0] STALL_CNT = SW'(STALL_LIMIT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RAMP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    // Unsigned distance |a - b|, evaluated in N+1 signed bits.
    function automatic logic [N-1:0] abs_diff(input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[N] ? N'(-d) : d[N-1:0];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [N-1:0]  prev_err_q, prev_err_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          fast_q, fast_d;
    logic          setval_q, setval_d;
    logic          busy_q, busy_d;
    logic          settled_q, settled_d;
    logic          stalled_q, stalled_d;

    logic [N:0]    diff;
    logic          diff_neg;
    logic [N-1:0]  err;
    logic [N-1:0]  set_err;
    logic          tick;
    logic          on_target;
    logic          want_fast;
    logic          shortcut_ok;
    logic [SW-1:0] stall_next;

    // Error terms shared by every state.
    always_comb begin
        diff        = {1'b0, bus.target} - {1'b0, bus.value};
        diff_neg    = diff[N];
        err         = abs_diff(bus.target, bus.value);
        set_err     = abs_diff(bus.target, SET_LVL);
        tick        = (presc_q == TICK_CNT);
        on_target   = (err <= DB_LVL);
        want_fast   = (err >= FAST_LVL);
        // A setval load only helps if it lands inside the deadband and the
        // remaining distance would otherwise take fast steps.
        shortcut_ok = (set_err <= DB_LVL) && want_fast;
    end

    // Next-state and command decision.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        stall_d    = stall_q;
        prev_err_d = prev_err_q;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        fast_d     = 1'b0;
        setval_d   = 1'b0;
        stall_next = '0;

        if (!bus.enable) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (!on_target) begin
                        state_d    = ST_RAMP;
                        prev_err_d = err;
                        stall_d    = '0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end

                ST_RAMP: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        prev_err_d = err;
                        if (on_target) begin
                            state_d = ST_SETTLE;
                        end else begin
                            // Any tick that fails to reduce the error counts
                            // toward a stall; one improving tick clears it.
                            stall_next = (err >= prev_err_q) ? stall_q + SW'(1) : '0;
                            stall_d    = stall_next;
                            if (stall_next == STALL_CNT) begin
                                state_d = ST_FAULT;
                            end else if (shortcut_ok) begin
                                setval_d = 1'b1;
                                state_d  = ST_SETTLE;
                            end else begin
                                inc_d  = !diff_neg;
                                dec_d  = diff_neg;
                                fast_d = want_fast;
                            end
                        end
                    end
                end

                ST_SETTLE: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick && !on_target) begin
                        state_d    = ST_RAMP;
                        stall_d    = '0;
                        prev_err_d = err;
                    end
                end

                ST_FAULT: begin
                    presc_d = '0;
                end

                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end

        busy_d    = (state_d == ST_RAMP);
        settled_d = (state_d == ST_SETTLE);
        stalled_d = (state_d == ST_FAULT);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            stall_q    <= '0;
            prev_err_q <= '0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            fast_q     <= 1'b0;
            setval_q   <= 1'b0;
            busy_q     <= 1'b0;
            settled_q  <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            stall_q    <= stall_d;
            prev_err_q <= prev_err_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            fast_q     <= fast_d;
            setval_q   <= setval_d;
            busy_q     <= busy_d;
            settled_q  <= settled_d;
            stalled_q  <= stalled_d;
        end
    end

    assign bus.inc     = inc_q;
    assign bus.dec     = dec_q;
    assign bus.fast    = fast_q;
    assign bus.setval  = setval_q;
    assign bus.busy    = busy_q;
    assign bus.settled = settled_q;
    assign bus.stalled = stalled_q;

endmodule

// File: tb/tb_nt_level_tracker.sv
// Directed bench for nt_level_tracker with a behavioural level resource
// (FAST_STEP = 3, setval loads 64) closing the feedback loop.
module tb_nt_level_tracker;

    localparam int PERIOD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nt_level_if #(.N(7)) bus ();

    nt_level_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Resource model and pulse bookkeeping controls.
    logic       mdl_load   = 1'b0;
    logic [6:0] mdl_val    = 7'd0;
    logic       mdl_ignore = 1'b0;
    logic       cnt_clr    = 1'b0;

    int n_inc    = 0;
    int n_dec    = 0;
    int n_fast   = 0;
    int n_set    = 0;
    int viol     = 0;
    int gap_bad  = 0;
    int cyc      = 0;
    int last_cyc = 0;
    bit have_last = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mdl_load)
            bus.value <= mdl_val;
        else if (!mdl_ignore) begin
            if (bus.setval)
                bus.value <= 7'd64;
            else if (bus.inc)
                bus.value <= bus.value + (bus.fast ? 7'd3 : 7'd1);
            else if (bus.dec)
                bus.value <= bus.value - (bus.fast ? 7'd3 : 7'd1);
        end

        if (cnt_clr) begin
            n_inc     <= 0;
            n_dec     <= 0;
            n_fast    <= 0;
            n_set     <= 0;
            viol      <= 0;
            gap_bad   <= 0;
            have_last <= 1'b0;
        end else begin
            if (bus.inc)    n_inc  <= n_inc + 1;
            if (bus.dec)    n_dec  <= n_dec + 1;
            if (bus.fast)   n_fast <= n_fast + 1;
            if (bus.setval) n_set  <= n_set + 1;
            if ((bus.inc && bus.dec) || (bus.setval && (bus.inc || bus.dec)) ||
                (bus.fast && !(bus.inc || bus.dec)))
                viol <= viol + 1;
            if (bus.inc || bus.dec || bus.setval) begin
                if (have_last && (cyc - last_cyc != PERIOD))
                    gap_bad <= gap_bad + 1;
                last_cyc  <= cyc;
                have_last <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Disable, preload the model value and target, clear counters, enable.
    task automatic start(input logic [6:0] v, input logic [6:0] t, input bit ign);
        @(negedge clk);
        bus.enable = 1'b0;
        mdl_ignore = ign;
        mdl_val    = v;
        mdl_load   = 1'b1;
        bus.target = t;
        cnt_clr    = 1'b1;
        @(negedge clk);
        mdl_load   = 1'b0;
        cnt_clr    = 1'b0;
        bus.enable = 1'b1;
    endtask

    task automatic wait_status(input string tag, input bit want_stall, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_stall ? bus.stalled : bus.settled) begin
                hit = 1'b1;
                break;
            end
        end
        check(tag, hit, 1);
    endtask

    function automatic logic [3:0] cmds();
        return {bus.inc, bus.dec, bus.fast, bus.setval};
    endfunction

    function automatic logic [2:0] status();
        return {bus.busy, bus.settled, bus.stalled};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with enable high.
        bus.enable = 1'b1;
        bus.target = 7'd100;
        mdl_val    = 7'd20;
        mdl_load   = 1'b1;
        cnt_clr    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {cmds(), status()}, 0);
        rst_n    = 1'b1;
        mdl_load = 1'b0;
        cnt_clr  = 1'b0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            check("rst_no_pulse", cmds(), 0);
        end
        check("rst_busy", bus.busy, 1);
        @(negedge clk);
        check("rst_first_tick", cmds(), 4'b1010);

        // Small decrement 96 -> 90.
        start(7'd96, 7'd90, 1'b0);
        wait_status("dec_settle", 1'b0, 100);
        repeat (2 * PERIOD) @(negedge clk);
        check("dec_count", n_dec, 4);
        check("dec_inc", n_inc, 0);
        check("dec_fast", n_fast, 0);
        check("dec_value", bus.value, 92);
        check("dec_settled", bus.settled, 1);
        check("dec_gap", gap_bad, 0);

        // Large increment 20 -> 100.
        start(7'd20, 7'd100, 1'b0);
        wait_status("big_settle", 1'b0, 400);
        repeat (2 * PERIOD) @(negedge clk);
        check("big_fast", n_fast, 22);
        check("big_inc", n_inc, 34);
        check("big_dec", n_dec, 0);
        check("big_value", bus.value, 98);
        check("big_settled", bus.settled, 1);
        check("big_gap", gap_bad, 0);

        // setval shortcut 120 -> 64.
        start(7'd120, 7'd64, 1'b0);
        wait_status("sc_settle", 1'b0, 40);
        repeat (PERIOD + 1) @(negedge clk);
        check("sc_setval", n_set, 1);
        check("sc_incdec", n_inc + n_dec, 0);
        check("sc_value", bus.value, 64);
        check("sc_settled", bus.settled, 1);

        // Abort by enable on the second tick edge.
        start(7'd20, 7'd100, 1'b0);
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abe_first_pulse", n_inc, 1);
        check("abe_busy_before", bus.busy, 1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("abe_cmds", cmds(), 0);
        check("abe_status", status(), 0);

        // Abort by reset on the second tick edge.
        start(7'd20, 7'd100, 1'b0);
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abr_first_pulse", n_inc, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abr_cmds", cmds(), 0);
        check("abr_status", status(), 0);
        rst_n = 1'b1;

        // Stall: resource ignores commands.
        start(7'd50, 7'd80, 1'b1);
        wait_status("stall_reach", 1'b1, 100);
        check("stall_inc", n_inc, 7);
        check("stall_fast", n_fast, 7);
        repeat (2 * PERIOD) @(negedge clk);
        check("stall_no_more", n_inc + n_dec + n_set, 7);
        check("stall_hold", bus.stalled, 1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("stall_release", status(), 0);
        mdl_ignore = 1'b0;

        check("protocol_viol", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
